tsip_timing_tx: RTL and testbench
=================================

Name: tsip_timing_tx

Overview:
- Generates TSIP 8F-AB primary timing packets: the transmit end of the timing-packet link that the Thunderbolt receiver path consumes.
- Used as an on-board Thunderbolt emulator for bring-up and loopback, and as a timing source for downstream clockmaster boards.
- Latches a time-of-day snapshot, frames it as DLE 8F AB payload DLE ETX with DLE byte-stuffing, and streams bytes to a uart_tx instance through its DV/Done handshake.

Parameters:
- TIMING_FLAGS, 8'h03, value sent in the timing-flags byte (bit0=UTC time, bit1=UTC PPS).
- CLKS_PER_SEC, 10_000_000, clocks per second for the auto-send timer (used only when the optional feature is enabled).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock; reset is asynchronous and active-low
- i_send  in  1  one-cycle request to send a packet; accepted only in IDLE
- i_tow  in  32  GPS time of week, seconds
- i_week  in  16  GPS week number
- i_utc_offset  in  16  UTC offset, seconds
- i_seconds, i_minutes, i_hour, i_day, i_month, i_year_h, i_year_l  in  8 each  UTC time fields
- o_tx_dv  out  1  one-cycle strobe to uart_tx i_Tx_DV
- o_tx_byte  out  8  byte to uart_tx i_Tx_Byte; held stable until the matching i_tx_done
- i_tx_done  in  1  uart_tx o_Tx_Done pulse
- o_busy  out  1  high from request acceptance until the last byte's done
- o_pkt_done  out  1  one-cycle pulse after ETX completes

Behaviour:
- Reset values:
  - o_tx_dv=0, o_tx_byte=8'h00, o_busy=0, o_pkt_done=0.
  - state=IDLE, byte index=0, stuff flag=0, snapshot registers=0.
- Logical frame, index 0..20:
  - 0: DLE(10). 1: 8F. 2: AB.
  - 3-6: TOW MSB first. 7-8: week MSB first. 9-10: UTC offset MSB first. 11: TIMING_FLAGS.
  - 12: seconds. 13: minutes. 14: hour. 15: day. 16: month. 17: year_h. 18: year_l.
  - 19: DLE. 20: ETX(03).
- Stuffing: any byte at indices 1..18 equal to 8'h10 is sent twice; indices 0, 19 and 20 are never stuffed. Wire length is 21 plus the number of payload DLEs.
- States:
  - IDLE: o_busy=0. If i_send=1: snapshot all inputs, index=0, go LOAD.
  - LOAD: o_tx_byte=frame[index], o_tx_dv=1 for exactly this cycle, go WAIT.
  - WAIT:
    - On i_tx_done, if the byte was a stuffable DLE and stuff flag=0: set stuff flag, go LOAD without advancing the index.
    - Otherwise clear stuff flag. If index==20 go DONE, else index+1 and go LOAD.
  - DONE: o_pkt_done=1 for one cycle, o_busy=0, go IDLE.
- Latency: i_send at cycle N gives o_tx_dv at N+2. Next byte's dv follows i_tx_done by 1 cycle.
- o_busy is set the cycle after i_send is accepted.
- i_send while busy, or in the DONE cycle, is ignored; it is not queued.
- i_tx_done outside WAIT is ignored.
- Inputs may change mid-packet; only the snapshot is transmitted.
- Reset asserted mid-packet: immediate return to the reset values. A partially transmitted frame is abandoned; uart_tx finishes its current byte on its own.

Optional Feature:
- Macro TSIP_AUTO_SEND_EN.
- Defined:
  - Internal counter 0..CLKS_PER_SEC-1 pulses a send request at wrap, ORed with i_send.
  - Counter reset value 0; wraps unconditionally.
  - If the packet is still busy at wrap, that second is skipped.
- Undefined: no counter; only i_send starts packets.

Decomposition:
- Package tsip_pkg holds:
  - TSIP_DLE=8'h10, TSIP_ETX=8'h03, TSIP_ID_TIM=8'h8F, TSIP_SUB_TIM=8'hAB.
  - TSIP_TIM_FRAME_LAST=20.
  - The state encodings: IDLE, LOAD, WAIT, DONE.
- One sub-module, tsip_timing_frame_mux: combinational index plus snapshot to frame byte, with a stuffable flag.

Test Plan:
- Basic frame:
  - Stimulus: 2024-03-15 12:34:56 (year_h=07, year_l=E8), TOW=0x00012345, week=0x08C1, offset=0x0012, i_send pulse; model i_tx_done 5 clocks after each dv.
  - Required: 21 bytes 10 8F AB 00 01 23 45 08 C1 00 12 03 38 22 0C 0F 03 07 E8 10 03, then one o_pkt_done.
- Stuffing: seconds=0x10, TOW=0x10101010, other values as the basic frame -> 26 bytes; each 10 doubled at its payload position; trailing 10 03 not doubled.
- Busy rejection: second i_send issued 3 clocks into a packet -> exactly one frame is sent; o_busy is high throughout it.
- Snapshot: change i_minutes from 0x22 to 0x2A after the first dv -> frame still carries 22.
- Reset mid-packet: i_rst low after byte 7 -> o_tx_dv=0 and o_busy=0 immediately. A new i_send after release yields a full frame starting with 10 8F.
- TSIP_AUTO_SEND_EN with CLKS_PER_SEC=5000 and an immediate-done uart model -> o_pkt_done every 5000 clocks with no i_send.

Source files
------------

// File: rtl/tsip_pkg.sv
// tsip_pkg: shared constants and types for the TSIP 8F-AB primary timing
// packet transmitter.
//   - TSIP framing bytes (DLE, ETX, packet id, sub-id)
//   - index of the last logical frame byte
//   - transmitter state encoding
//   - snapshot record latched when a packet is requested
package tsip_pkg;

  localparam logic [7:0] TSIP_DLE     = 8'h10;
  localparam logic [7:0] TSIP_ETX     = 8'h03;
  localparam logic [7:0] TSIP_ID_TIM  = 8'h8F;
  localparam logic [7:0] TSIP_SUB_TIM = 8'hAB;

  localparam int TSIP_TIM_FRAME_LAST = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } tsip_state_e;

  typedef struct packed {
    logic [31:0] tow;
    logic [15:0] week;
    logic [15:0] utc_offset;
    logic [7:0]  seconds;
    logic [7:0]  minutes;
    logic [7:0]  hour;
    logic [7:0]  day;
    logic [7:0]  month;
    logic [7:0]  year_h;
    logic [7:0]  year_l;
  } tsip_snap_t;

endpackage

// File: rtl/tsip_timing_frame_mux.sv
// tsip_timing_frame_mux: combinational lookup of one logical byte of the
// 21-byte TSIP 8F-AB frame (before DLE stuffing).
// Ports:
//   i_index          logical frame index 0..20
//   i_tow .. i_year_l snapshot fields
//   o_byte           frame byte at i_index
//   o_stuffable      byte is a payload DLE (index 1..18) that must be doubled
module tsip_timing_frame_mux
  import tsip_pkg::*;
#(
  parameter logic [7:0] TIMING_FLAGS = 8'h03
) (
  input  logic [4:0]  i_index,
  input  logic [31:0] i_tow,
  input  logic [15:0] i_week,
  input  logic [15:0] i_utc_offset,
  input  logic [7:0]  i_seconds,
  input  logic [7:0]  i_minutes,
  input  logic [7:0]  i_hour,
  input  logic [7:0]  i_day,
  input  logic [7:0]  i_month,
  input  logic [7:0]  i_year_h,
  input  logic [7:0]  i_year_l,
  output logic [7:0]  o_byte,
  output logic        o_stuffable
);

  // Multi-byte fields go out MSB first.
  always_comb begin
    o_byte = 8'h00;
    case (i_index)
      5'd0:  o_byte = TSIP_DLE;
      5'd1:  o_byte = TSIP_ID_TIM;
      5'd2:  o_byte = TSIP_SUB_TIM;
      5'd3:  o_byte = i_tow[31:24];
      5'd4:  o_byte = i_tow[23:16];
      5'd5:  o_byte = i_tow[15:8];
      5'd6:  o_byte = i_tow[7:0];
      5'd7:  o_byte = i_week[15:8];
      5'd8:  o_byte = i_week[7:0];
      5'd9:  o_byte = i_utc_offset[15:8];
      5'd10: o_byte = i_utc_offset[7:0];
      5'd11: o_byte = TIMING_FLAGS;
      5'd12: o_byte = i_seconds;
      5'd13: o_byte = i_minutes;
      5'd14: o_byte = i_hour;
      5'd15: o_byte = i_day;
      5'd16: o_byte = i_month;
      5'd17: o_byte = i_year_h;
      5'd18: o_byte = i_year_l;
      5'd19: o_byte = TSIP_DLE;
      5'd20: o_byte = TSIP_ETX;
      default: o_byte = 8'h00;
    endcase
  end

  // The opening DLE and the closing DLE ETX pair are framing, never stuffed.
  assign o_stuffable = (i_index >= 5'd1) && (i_index <= 5'd18) && (o_byte == TSIP_DLE);

endmodule

// File: rtl/tsip_timing_tx.sv
// tsip_timing_tx: builds a TSIP 8F-AB primary timing packet from a latched
// time-of-day snapshot and streams it byte by byte into a uart_tx through
// its DV/Done handshake, doubling payload DLE bytes.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-low reset
//   i_send             one-cycle packet request, honoured only when idle
//   i_tow .. i_year_l  time fields captured at request acceptance
//   o_tx_dv, o_tx_byte strobe and byte towards uart_tx (byte held until done)
//   i_tx_done          uart_tx byte-complete pulse
//   o_busy             packet in progress
//   o_pkt_done         one-cycle pulse once ETX has been sent
// Optional build macro TSIP_AUTO_SEND_EN adds a free-running once-per-second
// send request (CLKS_PER_SEC clocks) ORed with i_send.
module tsip_timing_tx
  import tsip_pkg::*;
#(
  parameter logic [7:0] TIMING_FLAGS = 8'h03,
  parameter int CLKS_PER_SEC = 10_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_send,
  input  logic [31:0] i_tow,
  input  logic [15:0] i_week,
  input  logic [15:0] i_utc_offset,
  input  logic [7:0]  i_seconds,
  input  logic [7:0]  i_minutes,
  input  logic [7:0]  i_hour,
  input  logic [7:0]  i_day,
  input  logic [7:0]  i_month,
  input  logic [7:0]  i_year_h,
  input  logic [7:0]  i_year_l,
  output logic        o_tx_dv,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_pkt_done
);

  localparam logic [4:0] LAST_IDX = 5'(TSIP_TIM_FRAME_LAST);

  tsip_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        stuff_q, stuff_d;
  tsip_snap_t  snap_q, snap_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        busy_q, busy_d;
  logic        pkt_done_q, pkt_done_d;

  logic [7:0]  frame_byte;
  logic        frame_stuffable;
  logic        send_req;

`ifdef TSIP_AUTO_SEND_EN
  localparam int CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_SEC - 1);

  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic             sec_tick;

  // Free-running second timer; a tick landing while a packet is still in
  // flight is simply dropped because requests are only honoured in IDLE.
  always_comb begin
    sec_tick  = (sec_cnt_q == CNT_LAST);
    sec_cnt_d = sec_tick ? '0 : sec_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sec_cnt_q <= '0;
    else        sec_cnt_q <= sec_cnt_d;
  end

  assign send_req = i_send | sec_tick;
`else
  assign send_req = i_send;
`endif

  tsip_timing_frame_mux #(
    .TIMING_FLAGS (TIMING_FLAGS)
  ) u_frame_mux (
    .i_index      (idx_q),
    .i_tow        (snap_q.tow),
    .i_week       (snap_q.week),
    .i_utc_offset (snap_q.utc_offset),
    .i_seconds    (snap_q.seconds),
    .i_minutes    (snap_q.minutes),
    .i_hour       (snap_q.hour),
    .i_day        (snap_q.day),
    .i_month      (snap_q.month),
    .i_year_h     (snap_q.year_h),
    .i_year_l     (snap_q.year_l),
    .o_byte       (frame_byte),
    .o_stuffable  (frame_stuffable)
  );

  // Next-state and registered-output logic. All outputs are flops, so the
  // strobe issued from LOAD is seen on the wire during the following cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stuff_d    = stuff_q;
    snap_d     = snap_q;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    tx_dv_d    = 1'b0;
    pkt_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (send_req) begin
          snap_d.tow        = i_tow;
          snap_d.week       = i_week;
          snap_d.utc_offset = i_utc_offset;
          snap_d.seconds    = i_seconds;
          snap_d.minutes    = i_minutes;
          snap_d.hour       = i_hour;
          snap_d.day        = i_day;
          snap_d.month      = i_month;
          snap_d.year_h     = i_year_h;
          snap_d.year_l     = i_year_l;
          idx_d             = 5'd0;
          stuff_d           = 1'b0;
          busy_d            = 1'b1;
          state_d           = LOAD;
        end
      end

      LOAD: begin
        tx_byte_d = frame_byte;
        tx_dv_d   = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        if (i_tx_done) begin
          // A payload DLE goes out twice: resend the same index once with
          // the stuff flag set, then advance normally.
          if (frame_stuffable && !stuff_q) begin
            stuff_d = 1'b1;
            state_d = LOAD;
          end else begin
            stuff_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              busy_d     = 1'b0;
              pkt_done_d = 1'b1;
              state_d    = DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = LOAD;
            end
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      idx_q      <= 5'd0;
      stuff_q    <= 1'b0;
      snap_q     <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      stuff_q    <= stuff_d;
      snap_q     <= snap_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign o_tx_dv    = tx_dv_q;
  assign o_tx_byte  = tx_byte_q;
  assign o_busy     = busy_q;
  assign o_pkt_done = pkt_done_q;

endmodule

// File: tb/tb_tsip_timing_tx.sv
// tb_tsip_timing_tx: self-checking bench for tsip_timing_tx. A packet-level
// model builds the expected stuffed wire bytes from the input fields at the
// moment a request is accepted; a single compare process checks every cycle
// against it, and a uart_tx model answers each strobe with a done pulse.
module tb_tsip_timing_tx;

  localparam int AUTO_PERIOD = 5000;

  logic        i_clk;
  logic        i_rst;
  logic        i_send;
  logic [31:0] i_tow;
  logic [15:0] i_week;
  logic [15:0] i_utc_offset;
  logic [7:0]  i_seconds, i_minutes, i_hour, i_day, i_month, i_year_h, i_year_l;
  logic        o_tx_dv;
  logic [7:0]  o_tx_byte;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_pkt_done;

  int testsRun = 0;
  int testsFailed = 0;
  int doneDelay = 4;
  int cyc = 0;
  int acceptCyc = 0;
  int sinceReset = 0;
  int pktDoneCount = 0;

  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];
  int         doneCycQ[$];
  bit         modelBusy = 0;
  bit         outstanding = 0;
  bit         expPktDone = 0;
  bit         ignoreNext = 0;
  bit         firstByte = 0;
  logic [7:0] lastByte = 8'h00;

  logic [7:0] basicLit[21] = '{8'h10, 8'h8F, 8'hAB, 8'h00, 8'h01, 8'h23, 8'h45,
                               8'h08, 8'hC1, 8'h00, 8'h12, 8'h03, 8'h38, 8'h22,
                               8'h0C, 8'h0F, 8'h03, 8'h07, 8'hE8, 8'h10, 8'h03};
  logic [7:0] stuffLit[26] = '{8'h10, 8'h8F, 8'hAB, 8'h10, 8'h10, 8'h10, 8'h10,
                               8'h10, 8'h10, 8'h10, 8'h10, 8'h08, 8'hC1, 8'h00,
                               8'h12, 8'h03, 8'h10, 8'h10, 8'h22, 8'h0C, 8'h0F,
                               8'h03, 8'h07, 8'hE8, 8'h10, 8'h03};

  tsip_timing_tx #(.TIMING_FLAGS(8'h03), .CLKS_PER_SEC(AUTO_PERIOD)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_send       (i_send),
    .i_tow        (i_tow),
    .i_week       (i_week),
    .i_utc_offset (i_utc_offset),
    .i_seconds    (i_seconds),
    .i_minutes    (i_minutes),
    .i_hour       (i_hour),
    .i_day        (i_day),
    .i_month      (i_month),
    .i_year_h     (i_year_h),
    .i_year_l     (i_year_l),
    .o_tx_dv      (o_tx_dv),
    .o_tx_byte    (o_tx_byte),
    .i_tx_done    (i_tx_done),
    .o_busy       (o_busy),
    .o_pkt_done   (o_pkt_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Expected wire bytes for a packet carrying the current input fields.
  function automatic void buildFrame();
    logic [7:0] f[21];
    f[0]  = 8'h10;  f[1]  = 8'h8F;  f[2]  = 8'hAB;
    f[3]  = i_tow[31:24]; f[4] = i_tow[23:16]; f[5] = i_tow[15:8]; f[6] = i_tow[7:0];
    f[7]  = i_week[15:8]; f[8] = i_week[7:0];
    f[9]  = i_utc_offset[15:8]; f[10] = i_utc_offset[7:0];
    f[11] = 8'h03;
    f[12] = i_seconds; f[13] = i_minutes; f[14] = i_hour; f[15] = i_day;
    f[16] = i_month;   f[17] = i_year_h;  f[18] = i_year_l;
    f[19] = 8'h10;  f[20] = 8'h03;
    for (int i = 0; i < 21; i++) begin
      expQ.push_back(f[i]);
      if (i >= 1 && i <= 18 && f[i] == 8'h10) expQ.push_back(f[i]);
    end
  endfunction

  // Packet-level reference and per-cycle comparison, sampled just after
  // each rising edge while inputs (driven on falling edges) are stable.
  always @(posedge i_clk) begin
    bit sendNow;
    #1;
    cyc++;
    if (!i_rst) begin
      checkOutput("reset_dv", o_tx_dv, 0);
      checkOutput("reset_busy", o_busy, 0);
      checkOutput("reset_pkt_done", o_pkt_done, 0);
      checkOutput("reset_byte", o_tx_byte, 8'h00);
      modelBusy = 0; outstanding = 0; expPktDone = 0; ignoreNext = 0; firstByte = 0;
      expQ.delete();
      sinceReset = 0;
    end else begin
      sinceReset++;
      sendNow = i_send;
`ifdef TSIP_AUTO_SEND_EN
      if ((sinceReset - 1) % AUTO_PERIOD == AUTO_PERIOD - 1) sendNow = 1;
`endif
      expPktDone = 0;
      if (modelBusy && outstanding && i_tx_done) begin
        outstanding = 0;
        if (expQ.size() == 0) begin
          modelBusy  = 0;
          expPktDone = 1;
        end
      end else if (!modelBusy && !ignoreNext && sendNow) begin
        modelBusy = 1;
        buildFrame();
        acceptCyc = cyc;
        firstByte = 1;
      end

      checkOutput("busy", o_busy, modelBusy);
      checkOutput("pkt_done", o_pkt_done, expPktDone);
      if (o_pkt_done) begin
        pktDoneCount++;
        doneCycQ.push_back(cyc);
      end

      if (o_tx_dv) begin
        if (!modelBusy || outstanding || expQ.size() == 0) begin
          checkOutput("unexpected_dv", 1, 0);
        end else begin
          logic [7:0] e;
          e = expQ.pop_front();
          checkOutput("tx_byte", o_tx_byte, e);
          gotQ.push_back(o_tx_byte);
          outstanding = 1;
          lastByte = o_tx_byte;
          if (firstByte) begin
            checkOutput("first_dv_latency", cyc - acceptCyc, 1);
            firstByte = 0;
          end
        end
      end else if (outstanding) begin
        checkOutput("byte_hold", o_tx_byte, lastByte);
      end
      ignoreNext = expPktDone;
    end
  end

  // uart_tx stand-in: done pulse a fixed number of clocks after each strobe.
  always begin
    @(posedge i_clk);
    #1;
    if (o_tx_dv && i_rst) begin
      repeat (doneDelay) @(posedge i_clk);
      @(negedge i_clk);
      i_tx_done = 1'b1;
      @(negedge i_clk);
      i_tx_done = 1'b0;
    end
  end

  task automatic setBasic();
    i_tow = 32'h0001_2345; i_week = 16'h08C1; i_utc_offset = 16'h0012;
    i_seconds = 8'h38; i_minutes = 8'h22; i_hour = 8'h0C; i_day = 8'h0F;
    i_month = 8'h03; i_year_h = 8'h07; i_year_l = 8'hE8;
  endtask

  task automatic applyStimulus();
    @(negedge i_clk); i_send = 1'b1;
    @(negedge i_clk); i_send = 1'b0;
  endtask

  task automatic waitPacket(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(posedge i_clk); #2;
      if (o_pkt_done) seen = 1;
    end
    checkOutput("pkt_timeout", seen, 1);
  endtask

  function automatic logic [7:0] randByte();
    return ($urandom_range(0, 2) == 0) ? 8'h10 : 8'($urandom);
  endfunction

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pkt0;
    bit ok;
    i_rst = 1'b0; i_send = 1'b0; i_tx_done = 1'b0;
    setBasic();
    #1;
    checkOutput("por_dv", o_tx_dv, 0);
    checkOutput("por_busy", o_busy, 0);
    checkOutput("por_byte", o_tx_byte, 8'h00);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);

`ifdef TSIP_AUTO_SEND_EN
    // Autonomous packets: no i_send at all, immediate done.
    doneDelay = 0;
    doneCycQ.delete();
    repeat (3 * AUTO_PERIOD + 200) @(negedge i_clk);
    checkOutput("auto_count", doneCycQ.size() >= 3, 1);
    for (int i = 1; i < doneCycQ.size(); i++)
      checkOutput("auto_period", doneCycQ[i] - doneCycQ[i-1], AUTO_PERIOD);
`else
    // Basic frame.
    gotQ.delete();
    applyStimulus();
    waitPacket(1000);
    checkOutput("basic_len", gotQ.size(), 21);
    for (int i = 0; i < 21 && i < gotQ.size(); i++) checkOutput("basic_byte", gotQ[i], basicLit[i]);
    repeat (3) @(negedge i_clk);

    // DLE stuffing in payload, not in framing.
    setBasic(); i_seconds = 8'h10; i_tow = 32'h1010_1010;
    gotQ.delete();
    applyStimulus();
    waitPacket(1500);
    checkOutput("stuff_len", gotQ.size(), 26);
    for (int i = 0; i < 26 && i < gotQ.size(); i++) checkOutput("stuff_byte", gotQ[i], stuffLit[i]);
    repeat (3) @(negedge i_clk);

    // Second request while busy is dropped.
    setBasic();
    pkt0 = pktDoneCount;
    applyStimulus();
    repeat (3) @(negedge i_clk);
    i_send = 1'b1; @(negedge i_clk); i_send = 1'b0;
    waitPacket(1000);
    repeat (200) @(negedge i_clk);
    checkOutput("busy_reject_frames", pktDoneCount - pkt0, 1);

    // Snapshot: fields changing after the first strobe are not sent.
    setBasic();
    gotQ.delete();
    applyStimulus();
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge i_clk);
      if (gotQ.size() >= 1) ok = 1;
    end
    checkOutput("snap_first_dv_seen", ok, 1);
    i_minutes = 8'h2A;
    waitPacket(1000);
    checkOutput("snap_minutes", (gotQ.size() > 13) ? gotQ[13] : 8'hFF, 8'h22);
    setBasic();
    repeat (3) @(negedge i_clk);

    // Reset mid-packet, then a clean restart.
    gotQ.delete();
    applyStimulus();
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge i_clk);
      if (gotQ.size() >= 8) ok = 1;
    end
    checkOutput("midrst_progress", ok, 1);
    i_rst = 1'b0;
    #1;
    checkOutput("midrst_dv", o_tx_dv, 0);
    checkOutput("midrst_busy", o_busy, 0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (20) @(negedge i_clk);
    gotQ.delete();
    applyStimulus();
    waitPacket(1000);
    checkOutput("restart_len", gotQ.size(), 21);
    checkOutput("restart_b0", (gotQ.size() > 0) ? gotQ[0] : 8'h00, 8'h10);
    checkOutput("restart_b1", (gotQ.size() > 1) ? gotQ[1] : 8'h00, 8'h8F);
    repeat (3) @(negedge i_clk);

    // Randomized packets with DLE-heavy fields, varying uart latency,
    // mid-packet input churn and spurious requests while busy.
    for (int p = 0; p < 25; p++) begin
      i_tow = {randByte(), randByte(), randByte(), randByte()};
      i_week = {randByte(), randByte()};
      i_utc_offset = {randByte(), randByte()};
      i_seconds = randByte(); i_minutes = randByte(); i_hour = randByte();
      i_day = randByte(); i_month = randByte(); i_year_h = randByte(); i_year_l = randByte();
      doneDelay = $urandom_range(0, 6);
      applyStimulus();
      ok = 0;
      for (int n = 0; n < 3000 && !ok; n++) begin
        @(negedge i_clk);
        if (o_pkt_done) begin
          ok = 1;
          i_send = 1'b0;
        end else begin
          i_send = o_busy && ($urandom_range(0, 7) == 0);
          if ($urandom_range(0, 3) == 0) i_tow = $urandom;
          if ($urandom_range(0, 3) == 0) i_seconds = randByte();
        end
      end
      i_send = 1'b0;
      checkOutput("rand_pkt_timeout", ok, 1);
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end
    repeat (20) @(negedge i_clk);
    checkOutput("rand_queue_drained", expQ.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
